// File: rtl/teststruct_seq.sv
// teststruct_seq: Wishbone-controlled sweep sequencer for the on-die test structures.
// Selects each structure in [FIRST, LAST], holds it for a settle time, strobes the
// sample pad for a hold time, then breaks before making the next select.
// Optional feature macro: TSSEQ_LOOP_EN (continuous sweeps via CTRL.LOOP).
module teststruct_seq #(
  parameter int unsigned N_DUT   = 16,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [N_DUT-1:0]   dut_sel_o,
  output logic               dut_en_o,
  output logic               sample_o,
  output logic               irq_o
);

  localparam int unsigned IW = (N_DUT > 1) ? $clog2(N_DUT) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_SAMPLE, S_NEXT, S_DONE
  } state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [DWELL_W-1:0]   cnt;
  logic [IW-1:0]        first_q, last_q;
  logic [DWELL_W-1:0]   dwell_q, hold_q;
  logic                 loop_q;
  logic                 err_q;
  logic [15:0]          sweeps_q;

  logic                 acc_c, wr_c, wr_ctrl_c, start_c, abort_c;
  logic [1:0]           reg_c;
  logic [IW-1:0]        first_nxt_c, last_nxt_c;
  logic [31:0]          be_full_c;
  logic [DWELL_W-1:0]   be_mask_c, dwell_eff_c, hold_eff_c;
  logic [31:0]          rdata_c;
  logic                 unused_bits_c;

  function automatic logic [IW-1:0] clamp_idx(input logic [3:0] v);
    if (32'(v) >= N_DUT) clamp_idx = IDX_MAX;
    else                 clamp_idx = IW'(v);
  endfunction

  function automatic logic [N_DUT-1:0] onehot(input logic [IW-1:0] i);
    onehot = {{(N_DUT-1){1'b0}}, 1'b1} << i;
  endfunction

  // Bus decode: a transaction is taken when cyc&stb are high outside the ack cycle
  assign acc_c     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_c      = acc_c & wbs_we_i;
  assign reg_c     = wbs_adr_i[3:2];
  assign wr_ctrl_c = wr_c & (reg_c == 2'd0);
  assign start_c   = wr_ctrl_c & wbs_sel_i[0] & wbs_dat_i[0];
  assign abort_c   = wr_ctrl_c & wbs_sel_i[0] & wbs_dat_i[1];
  assign be_full_c = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign be_mask_c = be_full_c[DWELL_W-1:0];
  assign dwell_eff_c = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign hold_eff_c  = (hold_q  == '0) ? DWELL_W'(1) : hold_q;
  // FIRST/LAST written together with START are used by that START
  assign first_nxt_c = (wr_ctrl_c && wbs_sel_i[1]) ? clamp_idx(wbs_dat_i[11:8])  : first_q;
  assign last_nxt_c  = (wr_ctrl_c && wbs_sel_i[1]) ? clamp_idx(wbs_dat_i[15:12]) : last_q;
  assign unused_bits_c = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

  // Register read mux; reserved bits and write-pulse bits read 0
  always_comb begin
    rdata_c = '0;
    case (reg_c)
      2'd0: begin
        rdata_c[2]     = loop_q;
        rdata_c[11:8]  = 4'(first_q);
        rdata_c[15:12] = 4'(last_q);
      end
      2'd1: rdata_c[DWELL_W-1:0] = dwell_q;
      2'd2: begin
        rdata_c[0]     = (state != S_IDLE);
        rdata_c[1]     = err_q;
        rdata_c[7:4]   = 4'(idx);
        rdata_c[31:16] = sweeps_q;
      end
      default: rdata_c[DWELL_W-1:0] = hold_q;
    endcase
  end

  // Wishbone slave: single-cycle ack, config registers with byte enables
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      first_q   <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      dwell_q   <= DWELL_W'(1);
      hold_q    <= DWELL_W'(1);
    end else begin
      wbs_ack_o <= acc_c;
      wbs_dat_o <= (acc_c && !wbs_we_i) ? rdata_c : '0;
      first_q   <= first_nxt_c;
      last_q    <= last_nxt_c;
`ifdef TSSEQ_LOOP_EN
      if (wr_ctrl_c && wbs_sel_i[0]) loop_q <= wbs_dat_i[2];
`endif
      if (wr_c && reg_c == 2'd1)
        dwell_q <= (dwell_q & ~be_mask_c) | (wbs_dat_i[DWELL_W-1:0] & be_mask_c);
      if (wr_c && reg_c == 2'd3)
        hold_q  <= (hold_q & ~be_mask_c) | (wbs_dat_i[DWELL_W-1:0] & be_mask_c);
    end
  end

  // Sweep FSM; outputs are registered to reflect the state being entered
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      sweeps_q  <= '0;
      dut_sel_o <= '0;
      dut_en_o  <= 1'b0;
      sample_o  <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      irq_o <= 1'b0;
      if (abort_c) begin
        state     <= S_IDLE;
        dut_sel_o <= '0;
        dut_en_o  <= 1'b0;
        sample_o  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_c) begin
              if (first_nxt_c <= last_nxt_c) begin
                state     <= S_SELECT;
                idx       <= first_nxt_c;
                err_q     <= 1'b0;
                dut_sel_o <= onehot(first_nxt_c);
                dut_en_o  <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_SELECT: begin
            state <= S_SETTLE;
            cnt   <= dwell_eff_c;
          end
          S_SETTLE: begin
            if (cnt <= DWELL_W'(1)) begin
              state    <= S_SAMPLE;
              cnt      <= hold_eff_c;
              sample_o <= 1'b1;
            end else begin
              cnt <= cnt - DWELL_W'(1);
            end
          end
          S_SAMPLE: begin
            if (cnt <= DWELL_W'(1)) begin
              state     <= S_NEXT;
              dut_sel_o <= '0;
              dut_en_o  <= 1'b0;
              sample_o  <= 1'b0;
            end else begin
              cnt <= cnt - DWELL_W'(1);
            end
          end
          S_NEXT: begin
            if (idx < last_q) begin
              state     <= S_SELECT;
              idx       <= idx + IW'(1);
              dut_sel_o <= onehot(idx + IW'(1));
              dut_en_o  <= 1'b1;
            end else begin
              state    <= S_DONE;
              irq_o    <= 1'b1;
              sweeps_q <= sweeps_q + 16'd1;
            end
          end
          S_DONE: begin
            if (loop_q) begin
              state     <= S_SELECT;
              idx       <= first_q;
              dut_sel_o <= onehot(first_q);
              dut_en_o  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_teststruct_seq.sv
// Bench for teststruct_seq: a cycle-timeline model of the sweep is built from the
// register values at START and compared against the DUT outputs every cycle.
module tb_teststruct_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic [15:0] dut_sel;
  logic        dut_en, smp, irq;

  teststruct_seq dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .dut_sel_o(dut_sel), .dut_en_o(dut_en), .sample_o(smp), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sel;
    bit          en;
    bit          smp;
    bit          irq;
    int          idx;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  int          m_first, m_last, m_idx;
  logic [15:0] m_dwell, m_hold, m_sweeps;
  bit          m_loop, m_err, cur_busy, chk_en;
  logic [15:0] prev_sel;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_first = 0; m_last = 0; m_idx = 0;
    m_dwell = 16'd1; m_hold = 16'd1; m_sweeps = 16'd0;
    m_loop = 1'b0; m_err = 1'b0;
  endfunction

  // One full pass as a timeline: per structure select+settle, sample, gap; then done
  function automatic void append_pass();
    int d, h;
    exp_t e;
    d = (m_dwell == 0) ? 1 : int'(m_dwell);
    h = (m_hold == 0) ? 1 : int'(m_hold);
    for (int i = m_first; i <= m_last; i++) begin
      e.sel = 16'd1 << i; e.en = 1; e.smp = 0; e.irq = 0; e.idx = i;
      for (int c = 0; c < 1 + d; c++) q.push_back(e);
      e.smp = 1;
      for (int c = 0; c < h; c++) q.push_back(e);
      e.sel = 16'd0; e.en = 0; e.smp = 0;
      q.push_back(e);
    end
    e.sel = 16'd0; e.en = 0; e.smp = 0; e.irq = 1; e.idx = m_last;
    q.push_back(e);
  endfunction

  function automatic logic [15:0] apply_be(input logic [15:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] v;
    v = {16'd0, old};
    for (int b = 0; b < 4; b++) if (be[b]) v[b*8 +: 8] = d[b*8 +: 8];
    return v[15:0];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    case (a[3:2])
      2'd0: begin
        if (be[1]) begin
          m_first = int'(d[11:8]);
          m_last  = int'(d[15:12]);
        end
`ifdef TSSEQ_LOOP_EN
        if (be[0]) m_loop = d[2];
`endif
        if (be[0] && d[1]) q.delete();
        else if (be[0] && d[0] && !cur_busy) begin
          if (m_first <= m_last) begin m_err = 0; append_pass(); end
          else m_err = 1;
        end
      end
      2'd1: m_dwell = apply_be(m_dwell, d, be);
      2'd3: m_hold  = apply_be(m_hold, d, be);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    case (a[3:2])
      2'd0: return (32'(m_loop) << 2) | (32'(m_first) << 8) | (32'(m_last) << 12);
      2'd1: return {16'd0, m_dwell};
      2'd2: return {m_sweeps, 8'd0, 4'(m_idx), 2'd0, m_err, cur_busy};
      default: return {16'd0, m_hold};
    endcase
  endfunction

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = a; dat_w = d; sel = be;
    @(posedge clk);
    model_write(a, d, be);
    #1; cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    check("wr_ack", 32'(ack), 32'd1);
  endtask

  task automatic wb_read(input string nm, input logic [31:0] a, output logic [31:0] d);
    logic [31:0] e;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hf;
    @(posedge clk);
    e = exp_read(a);
    #1; cyc = 0; stb = 0;
    @(negedge clk);
    check("rd_ack", 32'(ack), 32'd1);
    d = dat_r;
    check(nm, d, e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(q.size() == 0 && !cur_busy)) begin
      @(posedge clk);
      n++;
      if (n > 3000) begin
        check("wait_idle_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  // Per-cycle compare of all sweep outputs against the model timeline
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0) begin
        ce = q.pop_front();
        cur_busy = 1;
        m_idx = ce.idx;
        if (ce.irq) begin
          m_sweeps = m_sweeps + 16'd1;
          if (m_loop) append_pass();
        end
      end else begin
        ce.sel = 0; ce.en = 0; ce.smp = 0; ce.irq = 0; ce.idx = m_idx;
        cur_busy = 0;
      end
      check("dut_sel", 32'(dut_sel), 32'(ce.sel));
      check("dut_en", 32'(dut_en), 32'(ce.en));
      check("sample", 32'(smp), 32'(ce.smp));
      check("irq", 32'(irq), 32'(ce.irq));
      check("break_before_make",
            32'(prev_sel != 0 && dut_sel != 0 && prev_sel != dut_sel), 32'd0);
      check("sample_without_en", 32'(smp && !dut_en), 32'd0);
      prev_sel = dut_sel;
    end
  end

  initial begin
    logic [31:0] rd;
    int c2, c3, c4, ns, irqn, seen, last_irq, gap_ok;
    rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
    chk_en = 0; cur_busy = 0; prev_sel = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check("rst_sel", 32'(dut_sel), 32'd0);
    check("rst_en_smp_irq", {29'd0, dut_en, smp, irq}, 32'd0);
    chk_en = 1;

    // reset register values
    wb_read("status_rst", 32'h8, rd); check("status_rst_lit", rd, 32'h0);
    wb_read("dwell_rst", 32'h4, rd);  check("dwell_rst_lit", rd, 32'h1);

    // basic sweep 2..4, dwell 3, hold 2
    wb_write(32'h4, 32'd3, 4'hf);
    wb_write(32'hC, 32'd2, 4'hf);
    wb_write(32'h0, (32'd2 << 8) | (32'd4 << 12) | 32'd1, 4'b0011);
    c2 = 0; c3 = 0; c4 = 0; ns = 0; irqn = 0;
    for (int n = 1; n <= 30; n++) begin
      if (n > 1) @(negedge clk);
      if (dut_sel == 16'h0004) c2++;
      if (dut_sel == 16'h0008) c3++;
      if (dut_sel == 16'h0010) c4++;
      if (smp) ns++;
      if (irq) irqn = n;
    end
    check("sweep_sel2_cycles", 32'(c2), 32'd6);
    check("sweep_sel3_cycles", 32'(c3), 32'd6);
    check("sweep_sel4_cycles", 32'(c4), 32'd6);
    check("sweep_sample_cycles", 32'(ns), 32'd6);
    check("sweep_irq_cycle", 32'(irqn), 32'd22);
    wait_idle();
    wb_read("status_sweep", 32'h8, rd); check("status_sweep_lit", rd, 32'h0001_0040);

    // FIRST > LAST sets ERR; a valid START clears it
    wb_write(32'h0, (32'd5 << 8) | (32'd3 << 12) | 32'd1, 4'b0011);
    wait_idle();
    wb_read("status_err", 32'h8, rd); check("status_err_lit", rd, 32'h0001_0042);
    wb_write(32'h0, (32'd1 << 8) | (32'd1 << 12) | 32'd1, 4'b0011);
    wait_idle();
    wb_read("status_errclr", 32'h8, rd); check("status_errclr_lit", rd, 32'h0002_0010);

    // START while busy is ignored; ABORT in SETTLE
    wb_write(32'h4, 32'd5, 4'hf);
    wb_write(32'h0, (32'd0 << 8) | (32'd3 << 12) | 32'd1, 4'b0011);
    wb_write(32'h0, 32'd1, 4'b0001);
    wb_write(32'h0, 32'd2, 4'b0001);
    wait_idle();
    wb_read("status_abort", 32'h8, rd); check("status_abort_lit", rd, 32'h0002_0000);

    // continuous sweep on a single structure
    wb_write(32'h4, 32'd1, 4'hf);
    wb_write(32'hC, 32'd1, 4'hf);
    wb_write(32'h0, 32'h4, 4'b0011);
    wb_read("ctrl_loop", 32'h0, rd);
    wb_write(32'h0, 32'h5, 4'b0001);
`ifdef TSSEQ_LOOP_EN
    seen = 0; last_irq = 0; gap_ok = 1;
    for (int n = 1; n <= 100 && seen < 3; n++) begin
      if (n > 1) @(negedge clk);
      if (irq) begin
        if (n - last_irq != 5) gap_ok = 0;
        last_irq = n;
        seen++;
      end
    end
    check("loop_irq_count", 32'(seen), 32'd3);
    check("loop_irq_period", 32'(gap_ok), 32'd1);
    wb_write(32'h0, 32'h2, 4'b0001);
    wait_idle();
    wb_read("status_loop", 32'h8, rd); check("status_loop_lit", rd, 32'h0005_0000);
`else
    wait_idle();
    wb_read("status_loop", 32'h8, rd); check("status_loop_lit", rd, 32'h0003_0000);
`endif
    wb_write(32'h0, 32'h0, 4'b0001);
    wait_idle();

    // reset during SAMPLE
    wb_write(32'h4, 32'd2, 4'hf);
    wb_write(32'hC, 32'd3, 4'hf);
    wb_write(32'h0, (32'd6 << 8) | (32'd7 << 12) | 32'd1, 4'b0011);
    seen = 0;
    for (int n = 0; n < 50 && !smp; n++) @(negedge clk);
    check("reset_reached_sample", 32'(smp), 32'd1);
    rst_n = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    check("midrst_sel", 32'(dut_sel), 32'd0);
    check("midrst_en_smp_irq", {29'd0, dut_en, smp, irq}, 32'd0);
    wb_read("status_midrst", 32'h8, rd); check("status_midrst_lit", rd, 32'h0);
    wb_read("dwell_midrst", 32'h4, rd);  check("dwell_midrst_lit", rd, 32'h1);
    wb_read("hold_midrst", 32'hC, rd);   check("hold_midrst_lit", rd, 32'h1);
    wb_read("ctrl_midrst", 32'h0, rd);   check("ctrl_midrst_lit", rd, 32'h0);

    // randomized sweeps, aborts, ignored restarts and byte-enable writes
    for (int it = 0; it < 30; it++) begin
      int act, w;
      logic [31:0] d;
      d = {$urandom_range(0, 65535), 16'd0} | 32'($urandom_range(0, 3));
      wb_write(32'h4, d, 4'($urandom_range(0, 15)));
      d = {$urandom_range(0, 65535), 16'd0} | 32'($urandom_range(0, 3));
      wb_write(32'hC, d, 4'($urandom_range(0, 15)));
      d = {$urandom_range(0, 65535), 16'd0} | (32'($urandom_range(0, 15)) << 12)
          | (32'($urandom_range(0, 15)) << 8) | (32'($urandom_range(0, 31)) << 3) | 32'd1;
      wb_write(32'h0, d, 4'b0011 | 4'($urandom_range(0, 3) << 2));
      act = $urandom_range(0, 2);
      w = $urandom_range(0, 20);
      if (act != 0) begin
        repeat (w) @(negedge clk);
        if (act == 1) wb_write(32'h0, 32'h2, 4'b0001);
        else          wb_write(32'h0, (32'($urandom_range(0, 31)) << 3) | 32'd1, 4'b0001);
      end
      wait_idle();
      wb_read("rand_status", 32'h8, rd);
      wb_read("rand_ctrl", 32'h0, rd);
      wb_read("rand_dwell", 32'h4, rd);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
